// File: rtl/reg_file_sb.sv
// Parametrised register file with a per-register busy scoreboard for RAW hazard detection.
// Optional write-first bypass on both read ports when REG_BYPASS_EN is defined.
module reg_file_sb_rport #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = $clog2(NREG)
) (
  input  logic [NREG-1:0][DATA_W-1:0] mem_i,
  input  logic [NREG-1:0]             busy_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic                        byp_en_i,
  input  logic [ADDR_W-1:0]           waddr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        busy_o
);
  logic hit;

  assign hit     = byp_en_i && (addr_i == waddr_i);
  assign rdata_o = hit ? wdata_i : ((addr_i == '0) ? '0 : mem_i[addr_i]);
  // A bypassed read already carries the pending value, so it is no longer a hazard.
  assign busy_o  = busy_i[addr_i] & ~hit;
endmodule

module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              busy1,
  output logic              busy2,
  output logic              any_busy
);
  localparam int NPORT = 2;

  logic [NREG-1:0][DATA_W-1:0]  mem_q;
  logic [NREG-1:0]              busy_q, busy_d;
  logic [NREG-1:0]              wr_dec, mk_dec;
  logic [NPORT-1:0][ADDR_W-1:0] raddr;
  logic [NPORT-1:0][DATA_W-1:0] rdata;
  logic [NPORT-1:0]             rbusy;
  logic                         byp_en;

  always_comb begin
    wr_dec = '0;
    mk_dec = '0;
    if (we3)     wr_dec[A3]        = 1'b1;
    if (mark_en) mk_dec[mark_addr] = 1'b1;
    wr_dec[0] = 1'b0;
    mk_dec[0] = 1'b0;
  end

  // Mark is applied after clear: a newly issued producer owns the register.
  always_comb begin
    busy_d    = (busy_q & ~wr_dec) | mk_dec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        if (wr_dec[r]) mem_q[r] <= WD3;
      busy_q <= busy_d;
    end
  end

`ifdef REG_BYPASS_EN
  // Gated by reset so reads stay zero while reset is held.
  assign byp_en = reset && we3 && (A3 != '0);
`else
  assign byp_en = 1'b0;
`endif

  assign raddr[0] = A1;
  assign raddr[1] = A2;

  for (genvar p = 0; p < NPORT; p++) begin : g_rport
    reg_file_sb_rport #(
      .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)
    ) u_rport (
      .mem_i   (mem_q),
      .busy_i  (busy_q),
      .addr_i  (raddr[p]),
      .byp_en_i(byp_en),
      .waddr_i (A3),
      .wdata_i (WD3),
      .rdata_o (rdata[p]),
      .busy_o  (rbusy[p])
    );
  end

  assign RD1      = rdata[0];
  assign RD2      = rdata[1];
  assign busy1    = rbusy[0];
  assign busy2    = rbusy[1];
  assign any_busy = |busy_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, mid-cycle reset sequence, and random traffic
// against an array-based reference model. Expectations follow REG_BYPASS_EN when defined.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we3 = 1'b0, mark_en = 1'b0;
  logic [AW-1:0] A1 = '0, A2 = '0, A3 = '0, mark_addr = '0;
  logic [DW-1:0] WD3 = '0;
  logic [DW-1:0] RD1, RD2;
  logic          busy1, busy2, any_busy;

  reg_file_sb #(.DATA_W(DW), .NREG(NR)) dut (
    .clk(clk), .reset(reset), .we3(we3), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .mark_en(mark_en), .mark_addr(mark_addr), .RD1(RD1), .RD2(RD2),
    .busy1(busy1), .busy2(busy2), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] a1, a2, a3;
    logic [DW-1:0] wd;
    logic          mk;
    logic [AW-1:0] ma;
    logic [DW-1:0] e_rd1, e_rd2;
    logic          e_b1, e_b2, e_any;
  } vec_t;

  logic [DW-1:0] mdl_mem  [NR];
  logic          mdl_busy [NR];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int r = 0; r < NR; r++) begin
      mdl_mem[r]  = '0;
      mdl_busy[r] = 1'b0;
    end
  endtask

  function automatic logic m_hit(input logic [AW-1:0] a);
    return BYP && reset && we3 && (A3 != 0) && (a == A3);
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    if (m_hit(a)) return WD3;
    if (!reset || a == 0) return '0;
    return mdl_mem[a];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    if (!reset || m_hit(a)) return 1'b0;
    return mdl_busy[a];
  endfunction

  function automatic logic m_any();
    logic o = 1'b0;
    if (!reset) return 1'b0;
    for (int r = 0; r < NR; r++) o |= mdl_busy[r];
    return o;
  endfunction

  // Clock-edge effect on the model: clear-on-write, then set-on-mark.
  task automatic mdl_edge();
    if (we3 && A3 != 0) begin
      mdl_mem[A3]  = WD3;
      mdl_busy[A3] = 1'b0;
    end
    if (mark_en && mark_addr != 0) mdl_busy[mark_addr] = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rd1"},  RD1, m_rd(A1));
    chk({tag, ".rd2"},  RD2, m_rd(A2));
    chk({tag, ".b1"},   DW'(busy1), DW'(m_busy(A1)));
    chk({tag, ".b2"},   DW'(busy2), DW'(m_busy(A2)));
    chk({tag, ".any"},  DW'(any_busy), DW'(m_any()));
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] a3, input logic [DW-1:0] wd,
                       input logic mk, input logic [AW-1:0] ma);
    we3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd; mark_en = mk; mark_addr = ma;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (reset) mdl_edge();
    #1;
  endtask

  function automatic vec_t mkv(input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [AW-1:0] a3, input logic [DW-1:0] wd,
                               input logic mk, input logic [AW-1:0] ma,
                               input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                               input logic b1, input logic b2, input logic an);
    vec_t v;
    v.we = we; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.wd = wd; v.mk = mk; v.ma = ma;
    v.e_rd1 = r1; v.e_rd2 = r2; v.e_b1 = b1; v.e_b2 = b2; v.e_any = an;
    return v;
  endfunction

  initial begin
    vec_t vt [13];
    logic [DW-1:0] w1, w2, w3;

    // Outputs are checked in the cycle before the edge that commits each row.
    vt[0]  = mkv(0, 5,  31, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mkv(1, 7,  0,  7, 32'hDEADBEEF, 0, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 0);
    vt[2]  = mkv(1, 7,  0,  0, 32'hFFFFFFFF, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    vt[3]  = mkv(0, 0,  0,  0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mkv(0, 9,  7,  0, 32'h0,        1, 9, 0, 32'hDEADBEEF, 0, 0, 0);
    vt[5]  = mkv(1, 9,  9,  9, 32'h1234,     0, 0, BYP ? 32'h1234 : 32'h0, BYP ? 32'h1234 : 32'h0,
                 !BYP, !BYP, 1);
    vt[6]  = mkv(0, 9,  0,  0, 32'h0,        0, 0, 32'h1234, 0, 0, 0, 0);
    vt[7]  = mkv(0, 4,  0,  0, 32'h0,        1, 4, 0, 0, 0, 0, 0);
    vt[8]  = mkv(1, 4,  9,  4, 32'hAA,       1, 4, BYP ? 32'hAA : 32'h0, 32'h1234, !BYP, 0, 1);
    vt[9]  = mkv(0, 4,  4,  0, 32'h0,        0, 0, 32'hAA, 32'hAA, 1, 1, 1);
    vt[10] = mkv(1, 4,  0,  4, 32'hAB,       1, 3, BYP ? 32'hAB : 32'hAA, 0, !BYP, 0, 1);
    vt[11] = mkv(1, 3,  4,  3, 32'h55,       0, 0, BYP ? 32'h55 : 32'h0, 32'hAB, !BYP, 0, 1);
    vt[12] = mkv(0, 3,  3,  0, 32'h0,        0, 0, 32'h55, 32'h55, 0, 0, 0);

    mdl_clear();
    // Reset held for two cycles, with a write/mark attempt that must have no effect.
    drive(1, 5, 31, 5, 32'hCAFEF00D, 1, 31);
    repeat (2) @(posedge clk);
    #1;
    check_model("in_reset");
    chk("in_reset.rd1_zero", RD1, '0);
    drive(0, 5, 31, 0, '0, 0, 0);
    reset = 1'b1;
    #2;
    check_model("post_reset");

    foreach (vt[i]) begin
      drive(vt[i].we, vt[i].a1, vt[i].a2, vt[i].a3, vt[i].wd, vt[i].mk, vt[i].ma);
      #2;
      chk($sformatf("vec%0d.rd1", i), RD1, vt[i].e_rd1);
      chk($sformatf("vec%0d.rd2", i), RD2, vt[i].e_rd2);
      chk($sformatf("vec%0d.b1", i),  DW'(busy1), DW'(vt[i].e_b1));
      chk($sformatf("vec%0d.b2", i),  DW'(busy2), DW'(vt[i].e_b2));
      chk($sformatf("vec%0d.any", i), DW'(any_busy), DW'(vt[i].e_any));
      clock_edge();
    end

    // Randomised traffic, biased to a few low registers so collisions are frequent.
    for (int n = 0; n < 1500; n++) begin
      logic narrow;
      narrow = ($urandom_range(0, 3) != 0);
      drive(logic'($urandom_range(0, 1)),
            AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1)),
            AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1)),
            AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1)),
            $urandom(),
            logic'($urandom_range(0, 9) < 4),
            AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1)));
      #2;
      check_model($sformatf("rnd%0d", n));
      clock_edge();
    end

    // Reset asserted between edges must clear state without waiting for clk.
    w1 = 32'h11111111; w2 = 32'h22222222; w3 = 32'h33333333;
    drive(1, 0, 0, 1, w1, 0, 0); clock_edge();
    drive(1, 0, 0, 2, w2, 1, 5); clock_edge();
    drive(1, 0, 0, 3, w3, 1, 2); clock_edge();
    drive(0, 1, 2, 0, '0, 0, 0);
    #2;
    chk("mid.pre_rd1", RD1, w1);
    chk("mid.pre_rd2", RD2, w2);
    chk("mid.pre_b2",  DW'(busy2), DW'(1'b1));
    chk("mid.pre_any", DW'(any_busy), DW'(1'b1));
    reset = 1'b0;
    mdl_clear();
    #1;
    chk("mid.rd1",  RD1, '0);
    chk("mid.rd2",  RD2, '0);
    chk("mid.b2",   DW'(busy2), '0);
    chk("mid.any",  DW'(any_busy), '0);
    drive(1, 1, 3, 1, 32'h77777777, 0, 0);
    #1;
    chk("mid.byp_rd1", RD1, '0);
    chk("mid.rd2_r3",  RD2, '0);
    @(posedge clk);
    #1;
    drive(0, 1, 2, 0, '0, 0, 0);
    reset = 1'b1;
    #2;
    check_model("after_mid");
    chk("after_mid.rd2", RD2, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
